slack_update: RTL and testbench

SLACK_UPDATE -- requirements
Module: slack_update

---
 rtl/mpc_pkg.sv | 21 ++
 rtl/slack_lane.sv | 50 +++++
 rtl/slack_update.sv | 233 +++++++++++++++++++++++
 tb/tb_slack_update.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpc_pkg
// Description : Shared lane width, lane type and slack-update FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mpc_pkg;

    localparam int ELEM_WIDTH = 16;

    typedef logic signed [ELEM_WIDTH-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        UPDATE_Z   = 2'd1,
        UPDATE_V   = 2'd2,
        DONE_STATE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/slack_lane.sv
`default_nettype none
// ============================================================================
// Module      : slack_lane
// Description : One lane: saturating add, clamp to [lo,hi] (lo wins when
//               lo > hi), and exact unsigned |new - old|.
// Revision    : 1.0 - initial release
// ============================================================================
module slack_lane
    import mpc_pkg::*;
(
    input  lane_t                 i_a,
    input  lane_t                 i_b,
    input  lane_t                 i_lo,
    input  lane_t                 i_hi,
    input  lane_t                 i_old,
    output lane_t                 o_new,
    output logic [ELEM_WIDTH-1:0] o_diff
);

    localparam logic signed [ELEM_WIDTH:0] c_SUM_MAX = {2'b00, {(ELEM_WIDTH-1){1'b1}}};
    localparam logic signed [ELEM_WIDTH:0] c_SUM_MIN = {2'b11, {(ELEM_WIDTH-1){1'b0}}};

    logic signed [ELEM_WIDTH:0] w_sum;
    logic signed [ELEM_WIDTH:0] w_diff;
    lane_t                      w_sat;
    lane_t                      w_lim;

    // Sum with one guard bit, saturate, clamp high then low, then residual.
    always_comb begin
        w_sum = {i_a[ELEM_WIDTH-1], i_a} + {i_b[ELEM_WIDTH-1], i_b};
        if (w_sum > c_SUM_MAX) begin
            w_sat = c_SUM_MAX[ELEM_WIDTH-1:0];
        end else if (w_sum < c_SUM_MIN) begin
            w_sat = c_SUM_MIN[ELEM_WIDTH-1:0];
        end else begin
            w_sat = w_sum[ELEM_WIDTH-1:0];
        end
        // Applying the lower bound last makes lo win when the bounds cross.
        w_lim = (w_sat > i_hi) ? i_hi : w_sat;
        if (w_lim < i_lo) begin
            w_lim = i_lo;
        end
        w_diff = {w_lim[ELEM_WIDTH-1], w_lim} - {i_old[ELEM_WIDTH-1], i_old};
        o_new  = w_lim;
        // Magnitude never exceeds 2^ELEM_WIDTH-1, so the truncation is exact.
        o_diff = w_diff[ELEM_WIDTH] ? ELEM_WIDTH'(-w_diff) : w_diff[ELEM_WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/slack_update.sv
`default_nettype none
// ============================================================================
// Module      : slack_update
// Description : Slack pass over a horizon: z = clamp(u+y) for k=0..H-2, then
//               v = clamp(x+g) for k=0..H-1, 4 cycles per step, tracking the
//               largest per-lane change of z and v.
// Revision    : 1.0 - initial release
// ============================================================================
module slack_update #(
    parameter int STATE_DIM        = 12,
    parameter int INPUT_DIM        = 4,
    parameter int HORIZON          = 30,
    parameter int ELEM_WIDTH       = mpc_pkg::ELEM_WIDTH,
    parameter int DATA_WIDTH_INPUT = INPUT_DIM * ELEM_WIDTH,
    parameter int DATA_WIDTH_STATE = STATE_DIM * ELEM_WIDTH,
    parameter int ADDR_WIDTH       = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 active_horizon,
    input  logic [DATA_WIDTH_INPUT-1:0] umin,
    input  logic [DATA_WIDTH_INPUT-1:0] umax,
    input  logic [DATA_WIDTH_STATE-1:0] xmin,
    input  logic [DATA_WIDTH_STATE-1:0] xmax,
    output logic [ADDR_WIDTH-1:0]       u_rdaddress,
    output logic [ADDR_WIDTH-1:0]       y_rdaddress,
    output logic [ADDR_WIDTH-1:0]       z_rdaddress,
    input  logic [DATA_WIDTH_INPUT-1:0] u_data_out,
    input  logic [DATA_WIDTH_INPUT-1:0] y_data_out,
    input  logic [DATA_WIDTH_INPUT-1:0] z_data_out,
    output logic [ADDR_WIDTH-1:0]       z_wraddress,
    output logic [DATA_WIDTH_INPUT-1:0] z_data_in,
    output logic                        z_wren,
    output logic [ADDR_WIDTH-1:0]       x_rdaddress,
    output logic [ADDR_WIDTH-1:0]       g_rdaddress,
    output logic [ADDR_WIDTH-1:0]       v_rdaddress,
    input  logic [DATA_WIDTH_STATE-1:0] x_data_out,
    input  logic [DATA_WIDTH_STATE-1:0] g_data_out,
    input  logic [DATA_WIDTH_STATE-1:0] v_data_out,
    output logic [ADDR_WIDTH-1:0]       v_wraddress,
    output logic [DATA_WIDTH_STATE-1:0] v_data_in,
    output logic                        v_wren,
    output logic [ELEM_WIDTH-1:0]       dua_res_u,
    output logic [ELEM_WIDTH-1:0]       dua_res_x,
    output logic                        done
);

    mpc_pkg::state_t             r_state;
    logic [1:0]                  r_ph;        // step phase P0..P3
    logic [ADDR_WIDTH-1:0]       r_k;         // current step index
    logic [31:0]                 r_h;         // horizon latched at start
    logic [ADDR_WIDTH-1:0]       r_zrd;
    logic [ADDR_WIDTH-1:0]       r_vrd;
    logic [ADDR_WIDTH-1:0]       r_zwa;
    logic [ADDR_WIDTH-1:0]       r_vwa;
    logic [DATA_WIDTH_INPUT-1:0] r_zdin;
    logic [DATA_WIDTH_STATE-1:0] r_vdin;
    logic                        r_zwe;
    logic                        r_vwe;
    logic                        r_done;
    logic [ELEM_WIDTH-1:0]       r_max_u;
    logic [ELEM_WIDTH-1:0]       r_max_x;
    logic [ELEM_WIDTH-1:0]       r_res_u;
    logic [ELEM_WIDTH-1:0]       r_res_x;

    logic [ELEM_WIDTH-1:0]       w_z_new  [INPUT_DIM];
    logic [ELEM_WIDTH-1:0]       w_z_diff [INPUT_DIM];
    logic [ELEM_WIDTH-1:0]       w_v_new  [STATE_DIM];
    logic [ELEM_WIDTH-1:0]       w_v_diff [STATE_DIM];
    logic [DATA_WIDTH_INPUT-1:0] w_z_pack;
    logic [DATA_WIDTH_STATE-1:0] w_v_pack;
    logic [ELEM_WIDTH-1:0]       w_z_max;
    logic [ELEM_WIDTH-1:0]       w_v_max;
    logic [31:0]                 w_h_eff;

    assign w_h_eff = (active_horizon > 32'(HORIZON)) ? 32'(HORIZON) : active_horizon;

    // Lanes compute straight off the memory outputs; the result is only
    // registered in P2, when the read data for step k is valid.
    for (genvar i = 0; i < INPUT_DIM; i++) begin : g_zlane
        slack_lane u_lane (
            .i_a    (u_data_out[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_b    (y_data_out[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_lo   (umin[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_hi   (umax[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_old  (z_data_out[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .o_new  (w_z_new[i]),
            .o_diff (w_z_diff[i])
        );
    end

    for (genvar i = 0; i < STATE_DIM; i++) begin : g_vlane
        slack_lane u_lane (
            .i_a    (x_data_out[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_b    (g_data_out[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_lo   (xmin[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_hi   (xmax[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .i_old  (v_data_out[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .o_new  (w_v_new[i]),
            .o_diff (w_v_diff[i])
        );
    end

    // Pack lane results into memory words and reduce residuals to a maximum.
    always_comb begin
        w_z_pack = '0;
        w_v_pack = '0;
        w_z_max  = '0;
        w_v_max  = '0;
        for (int i = 0; i < INPUT_DIM; i++) begin
            w_z_pack[i*ELEM_WIDTH +: ELEM_WIDTH] = w_z_new[i];
            if (w_z_diff[i] > w_z_max) w_z_max = w_z_diff[i];
        end
        for (int i = 0; i < STATE_DIM; i++) begin
            w_v_pack[i*ELEM_WIDTH +: ELEM_WIDTH] = w_v_new[i];
            if (w_v_diff[i] > w_v_max) w_v_max = w_v_diff[i];
        end
    end

    // Pass sequencer: FSM, 4-phase step counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= mpc_pkg::IDLE;
            r_ph    <= '0;
            r_k     <= '0;
            r_h     <= '0;
            r_zrd   <= '0;
            r_vrd   <= '0;
            r_zwa   <= '0;
            r_vwa   <= '0;
            r_zdin  <= '0;
            r_vdin  <= '0;
            r_zwe   <= 1'b0;
            r_vwe   <= 1'b0;
            r_done  <= 1'b0;
            r_max_u <= '0;
            r_max_x <= '0;
            r_res_u <= '0;
            r_res_x <= '0;
        end else begin
            case (r_state)
                mpc_pkg::IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_h     <= w_h_eff;
                        r_k     <= '0;
                        r_ph    <= '0;
                        r_zrd   <= '0;
                        r_vrd   <= '0;
                        r_max_u <= '0;
                        r_max_x <= '0;
                        if (w_h_eff == 32'd0) begin
                            r_state <= mpc_pkg::DONE_STATE;
                            r_res_u <= '0;
                            r_res_x <= '0;
                        end else if (w_h_eff == 32'd1) begin
                            r_state <= mpc_pkg::UPDATE_V;
                        end else begin
                            r_state <= mpc_pkg::UPDATE_Z;
                        end
                    end
                end
                mpc_pkg::UPDATE_Z: begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == 2'd2) begin
                        r_zwe   <= 1'b1;
                        r_zwa   <= r_k;
                        r_zdin  <= w_z_pack;
                        r_max_u <= (w_z_max > r_max_u) ? w_z_max : r_max_u;
                    end else if (r_ph == 2'd3) begin
                        r_zwe <= 1'b0;
                        if (32'(r_k) == r_h - 32'd2) begin
                            r_state <= mpc_pkg::UPDATE_V;
                            r_k     <= '0;
                            r_zrd   <= '0;
                            r_vrd   <= '0;
                        end else begin
                            r_k   <= r_k + ADDR_WIDTH'(1);
                            r_zrd <= r_k + ADDR_WIDTH'(1);
                        end
                    end
                end
                mpc_pkg::UPDATE_V: begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == 2'd2) begin
                        r_vwe   <= 1'b1;
                        r_vwa   <= r_k;
                        r_vdin  <= w_v_pack;
                        r_max_x <= (w_v_max > r_max_x) ? w_v_max : r_max_x;
                    end else if (r_ph == 2'd3) begin
                        r_vwe <= 1'b0;
                        if (32'(r_k) == r_h - 32'd1) begin
                            r_state <= mpc_pkg::DONE_STATE;
                            r_res_u <= r_max_u;
                            r_res_x <= r_max_x;
                        end else begin
                            r_k   <= r_k + ADDR_WIDTH'(1);
                            r_vrd <= r_k + ADDR_WIDTH'(1);
                        end
                    end
                end
                mpc_pkg::DONE_STATE: begin
                    // done is asserted for at least one cycle, then held while start stays high.
                    r_done <= 1'b1;
                    if (r_done && !start) begin
                        r_state <= mpc_pkg::IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= mpc_pkg::IDLE;
            endcase
        end
    end

    assign u_rdaddress = r_zrd;
    assign y_rdaddress = r_zrd;
    assign z_rdaddress = r_zrd;
    assign x_rdaddress = r_vrd;
    assign g_rdaddress = r_vrd;
    assign v_rdaddress = r_vrd;
    assign z_wraddress = r_zwa;
    assign z_data_in   = r_zdin;
    assign z_wren      = r_zwe;
    assign v_wraddress = r_vwa;
    assign v_data_in   = r_vdin;
    assign v_wren      = r_vwe;
    assign dua_res_u   = r_res_u;
    assign dua_res_x   = r_res_x;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_slack_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_slack_update
// Description : Scoreboard bench for slack_update with 2-cycle-latency
//               memory models for u, y, z, x, g and v.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slack_update;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  active_horizon;
    logic [63:0]  umin, umax;
    logic [191:0] xmin, xmax;
    logic [8:0]   u_rdaddress, y_rdaddress, z_rdaddress;
    logic [63:0]  u_data_out, y_data_out, z_data_out;
    logic [8:0]   z_wraddress;
    logic [63:0]  z_data_in;
    logic         z_wren;
    logic [8:0]   x_rdaddress, g_rdaddress, v_rdaddress;
    logic [191:0] x_data_out, g_data_out, v_data_out;
    logic [8:0]   v_wraddress;
    logic [191:0] v_data_in;
    logic         v_wren;
    logic [15:0]  dua_res_u, dua_res_x;
    logic         done;

    slack_update dut (
        .clk(clk), .rst(rst), .start(start), .active_horizon(active_horizon),
        .umin(umin), .umax(umax), .xmin(xmin), .xmax(xmax),
        .u_rdaddress(u_rdaddress), .y_rdaddress(y_rdaddress), .z_rdaddress(z_rdaddress),
        .u_data_out(u_data_out), .y_data_out(y_data_out), .z_data_out(z_data_out),
        .z_wraddress(z_wraddress), .z_data_in(z_data_in), .z_wren(z_wren),
        .x_rdaddress(x_rdaddress), .g_rdaddress(g_rdaddress), .v_rdaddress(v_rdaddress),
        .x_data_out(x_data_out), .g_data_out(g_data_out), .v_data_out(v_data_out),
        .v_wraddress(v_wraddress), .v_data_in(v_data_in), .v_wren(v_wren),
        .dua_res_u(dua_res_u), .dua_res_x(dua_res_x), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with two register stages on the read path.
    logic [63:0]  u_m [512];
    logic [63:0]  y_m [512];
    logic [63:0]  z_m [512];
    logic [191:0] x_m [512];
    logic [191:0] g_m [512];
    logic [191:0] v_m [512];
    logic [63:0]  u_p1, y_p1, z_p1, u_p2, y_p2, z_p2;
    logic [191:0] x_p1, g_p1, v_p1, x_p2, g_p2, v_p2;

    always @(posedge clk) begin
        u_p1 <= u_m[u_rdaddress]; u_p2 <= u_p1;
        y_p1 <= y_m[y_rdaddress]; y_p2 <= y_p1;
        z_p1 <= z_m[z_rdaddress]; z_p2 <= z_p1;
        x_p1 <= x_m[x_rdaddress]; x_p2 <= x_p1;
        g_p1 <= g_m[g_rdaddress]; g_p2 <= g_p1;
        v_p1 <= v_m[v_rdaddress]; v_p2 <= v_p1;
        if (z_wren) z_m[z_wraddress] <= z_data_in;
        if (v_wren) v_m[v_wraddress] <= v_data_in;
    end
    assign u_data_out = u_p2; assign y_data_out = y_p2; assign z_data_out = z_p2;
    assign x_data_out = x_p2; assign g_data_out = g_p2; assign v_data_out = v_p2;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit           is_v;
        logic [8:0]   addr;
        logic [191:0] data;
    } exp_t;
    exp_t q[$];

    int exp_u, exp_x, nz, nv;

    function automatic int lane_of(input logic [191:0] w, input int i);
        logic [15:0] t;
        t = w[i*16 +: 16];
        return int'($signed(t));
    endfunction

    function automatic int f_slack(input int a, input int b, input int lo, input int hi);
        int s;
        s = a + b;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    function automatic int f_abs(input int d);
        return (d < 0) ? -d : d;
    endfunction

    // Predict every write of the pass and both residual maxima.
    task automatic build_exp(input int h);
        int h_eff, n, d;
        logic [191:0] word;
        h_eff = (h > 30) ? 30 : h;
        nz = (h_eff >= 2) ? h_eff - 1 : 0;
        nv = h_eff;
        exp_u = 0;
        exp_x = 0;
        for (int k = 0; k < nz; k++) begin
            word = '0;
            for (int i = 0; i < 4; i++) begin
                n = f_slack(lane_of(u_m[k], i), lane_of(y_m[k], i), lane_of(umin, i), lane_of(umax, i));
                d = f_abs(n - lane_of(z_m[k], i));
                if (d > exp_u) exp_u = d;
                word[i*16 +: 16] = 16'(n);
            end
            q.push_back('{1'b0, 9'(k), word});
        end
        for (int k = 0; k < nv; k++) begin
            word = '0;
            for (int i = 0; i < 12; i++) begin
                n = f_slack(lane_of(x_m[k], i), lane_of(g_m[k], i), lane_of(xmin, i), lane_of(xmax, i));
                d = f_abs(n - lane_of(v_m[k], i));
                if (d > exp_x) exp_x = d;
                word[i*16 +: 16] = 16'(n);
            end
            q.push_back('{1'b1, 9'(k), word});
        end
    endtask

    // Write monitor: every write pulse is popped from the scoreboard.
    always @(negedge clk) begin
        if (z_wren || v_wren) begin
            exp_t e;
            n_wr++;
            check("wren_mutex", {191'b0, z_wren & v_wren}, 192'd0);
            if (q.size() == 0) begin
                check("sb_unexpected_write", 192'(q.size()), 192'd1);
            end else begin
                e = q.pop_front();
                check("wr_kind", {191'b0, v_wren}, {191'b0, e.is_v});
                check("wr_addr", v_wren ? 192'(v_wraddress) : 192'(z_wraddress), 192'(e.addr));
                check("wr_data", v_wren ? v_data_in : {128'b0, z_data_in}, e.data);
            end
        end
    end

    task automatic run_pass(input int h, input bit pulse);
        int cyc, w0, exp_cyc;
        build_exp(h);
        exp_cyc = (nv == 0) ? 1 : 4 * (nz + nv) + 1;
        w0 = n_wr;
        @(negedge clk);
        active_horizon = 32'(h);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (pulse) begin
                start = (cyc == 4 * nz + 5);
                if (cyc == 4 * nz + 5) active_horizon = 32'd7;
            end
        end
        start = 1'b0;
        check("done_cycle", 192'(cyc), 192'(exp_cyc));
        check("dua_res_u", 192'(dua_res_u), 192'(exp_u));
        check("dua_res_x", 192'(dua_res_x), 192'(exp_x));
        check("sb_drained", 192'(q.size()), 192'd0);
        check("write_count", 192'(n_wr - w0), 192'(nz + nv));
        @(posedge clk);
        #1 check("done_clear", {191'b0, done}, 192'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, {191'b0, done}, 192'd0);
        check({tag, "_wren"}, {190'b0, z_wren, v_wren}, 192'd0);
        check({tag, "_rdaddr"}, {174'b0, u_rdaddress, v_rdaddress}, 192'd0);
        check({tag, "_wraddr"}, {174'b0, z_wraddress, v_wraddress}, 192'd0);
        check({tag, "_din"}, v_data_in | {128'b0, z_data_in}, 192'd0);
        check({tag, "_res"}, {160'b0, dua_res_u, dua_res_x}, 192'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; active_horizon = '0;
        umin = '0; umax = '0; xmin = '0; xmax = '0;
        for (int k = 0; k < 512; k++) begin
            u_m[k] = '0; y_m[k] = '0; z_m[k] = '0;
            x_m[k] = '0; g_m[k] = '0; v_m[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Clamp to umax, small v update: z=120 everywhere, done at cycle 21.
        for (int k = 0; k < 32; k++) begin
            u_m[k] = {4{16'd100}};  y_m[k] = {4{16'd50}};
            x_m[k] = {12{16'd1}};   g_m[k] = {12{16'd2}};
        end
        umin = {4{16'hFF38}}; umax = {4{16'd120}};
        xmin = {12{16'hFC18}}; xmax = {12{16'd1000}};
        run_pass(3, 1'b0);
        check("z0_is_120", {128'b0, z_m[0]}, {128'b0, {4{16'd120}}});
        check("z1_is_120", {128'b0, z_m[1]}, {128'b0, {4{16'd120}}});
        check("res_u_is_120", 192'(dua_res_u), 192'd120);

        // Saturating add at the positive rail.
        for (int k = 0; k < 32; k++) begin
            x_m[k] = {12{16'h7FFF}}; g_m[k] = {12{16'd10}};
        end
        xmin = {12{16'h8000}}; xmax = {12{16'h7FFF}};
        run_pass(2, 1'b0);
        check("v0_saturated", v_m[0], {12{16'h7FFF}});

        // Crossed bounds: min wins.
        for (int k = 0; k < 32; k++) begin
            u_m[k] = '0; y_m[k] = '0;
        end
        umin = {4{16'd50}}; umax = {4{16'hFFCE}};
        run_pass(2, 1'b0);
        check("z0_crossed_bounds", {128'b0, z_m[0]}, {128'b0, {4{16'd50}}});

        // Empty horizon, then single step (no z phase).
        run_pass(0, 1'b0);
        run_pass(1, 1'b0);

        // Random data and bounds, including a horizon beyond the maximum.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 32; k++) begin
                u_m[k] = {$urandom, $urandom}; y_m[k] = {$urandom, $urandom};
                x_m[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                g_m[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            umin = {$urandom, $urandom}; umax = {$urandom, $urandom};
            xmin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            xmax = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_pass((r == 0) ? 6 : 40, 1'b0);
        end

        // start pulsed (and horizon changed) during UPDATE_V is ignored.
        run_pass(4, 1'b1);

        // Reset during P2 of v step 1 aborts the pass.
        build_exp(3);
        w0 = n_wr;
        @(negedge clk);
        active_horizon = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("abort");
        q.delete();
        check("abort_writes", 192'(n_wr - w0), 192'd3);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("abort_no_more_writes", 192'(n_wr - w0), 192'd3);
        run_pass(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
